// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and state encoding for the Wishbone block master
package wb_pkg;
  localparam int ADR_W = 12;
  localparam int DAT_W = 8;
  localparam int LEN_W = 4;
  typedef enum logic [1:0] {IDLE, BUS, DONE, ERR} state_t;
endpackage

// File: rtl/wb_timeout.sv
// wb_timeout: per-beat wait counter, expired on the last permitted wait cycle
module wb_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign expired = cnt == CW'(TIMEOUT - 1);
endmodule

// File: rtl/wishbone_master.sv
// wishbone_master: block read/write master issuing back-to-back Wishbone beats with per-beat timeout
module wishbone_master
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic             req_we_i,
  input  logic [ADR_W-1:0] req_adr_i,
  input  logic [LEN_W-1:0] req_len_i,
  input  logic [DAT_W-1:0] wr_dat_i,
  output logic             wr_rdy_o,
  output logic [DAT_W-1:0] rd_dat_o,
  output logic             rd_vld_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [ADR_W-1:0] adr_o,
  output logic [DAT_W-1:0] dat_o,
  output logic             we_o,
  output logic             stb_o,
  output logic             cyc_o,
  input  logic [DAT_W-1:0] dat_i,
  input  logic             ack_i
);
  state_t state, next;
  logic [LEN_W-1:0] len, beat;
  logic expired, in_bus, beat_done;
  assign in_bus    = state == BUS;
  assign beat_done = in_bus && ack_i;
  wb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr    (!in_bus || ack_i),
    .en     (in_bus && !ack_i),
    .expired(expired)
  );
  always_comb begin
    next = IDLE;
    if (state == IDLE) next = req_i ? BUS : IDLE;
    else if (in_bus) next = ack_i ? ((beat == len) ? DONE : BUS) : (expired ? ERR : BUS);
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state <= IDLE;
    else state <= next;
  // cyc/stb are flops that track the next state so they rise and fall on the same edge as BUS
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      {adr_o, we_o, len, beat, cyc_o, stb_o, rd_dat_o, rd_vld_o} <= '0;
    end else begin
      cyc_o    <= next == BUS;
      stb_o    <= next == BUS;
      rd_vld_o <= beat_done && !we_o;
      if (beat_done && !we_o) rd_dat_o <= dat_i;
      if (state == IDLE && req_i) begin
        adr_o <= req_adr_i;
        we_o  <= req_we_i;
        len   <= req_len_i;
        beat  <= '0;
      end else if (beat_done) begin
        adr_o <= adr_o + 1'b1;
        beat  <= beat + 1'b1;
      end
    end
  assign wr_rdy_o = beat_done && we_o;
  assign dat_o    = (in_bus && we_o) ? wr_dat_i : '0;
  assign busy_o   = state != IDLE;
  assign done_o   = state == DONE;
  assign err_o    = state == ERR;
endmodule

// File: tb/tb_wishbone_master.sv
// tb_wishbone_master: directed checks of the block master against a simple memory slave
module tb_wishbone_master;
  logic        clk_i = 0, rst_i = 0;
  logic        req_i = 0, req_we_i = 0;
  logic [11:0] req_adr_i = '0;
  logic [3:0]  req_len_i = '0;
  logic [7:0]  wr_dat_i, rd_dat_o, dat_o, dat_i;
  logic        wr_rdy_o, rd_vld_o, busy_o, done_o, err_o, we_o, stb_o, cyc_o, ack_i;
  logic [11:0] adr_o;

  wishbone_master #(.TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .req_we_i(req_we_i),
    .req_adr_i(req_adr_i), .req_len_i(req_len_i), .wr_dat_i(wr_dat_i),
    .wr_rdy_o(wr_rdy_o), .rd_dat_o(rd_dat_o), .rd_vld_o(rd_vld_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .adr_o(adr_o),
    .dat_o(dat_o), .we_o(we_o), .stb_o(stb_o), .cyc_o(cyc_o),
    .dat_i(dat_i), .ack_i(ack_i)
  );

  always #5 clk_i = ~clk_i;

  // slave: read data is adr+0x4A, writes land in wmem, optional wait states or no ack at all
  int         waits = 0;
  logic       noack = 0;
  int         wcnt;
  logic [7:0] wmem [4096];
  assign ack_i = cyc_o && stb_o && !noack && (wcnt == waits);
  assign dat_i = adr_o[7:0] + 8'h4A;
  always @(posedge clk_i or negedge rst_i)
    if (!rst_i) wcnt <= 0;
    else wcnt <= (cyc_o && stb_o && !ack_i) ? wcnt + 1 : 0;
  always @(posedge clk_i)
    if (ack_i && we_o) wmem[adr_o] <= dat_o;

  // write source advances one byte per accepted beat
  logic [7:0] wdata [4];
  int widx = 0, wbase = 0;
  assign wr_dat_i = wdata[2'(widx - wbase)];
  always @(posedge clk_i)
    if (wr_rdy_o) widx <= widx + 1;

  int          cyc_n, wr_n, done_n, err_n;
  logic [11:0] adr_q[$];
  logic [7:0]  rd_q[$];
  always @(negedge clk_i) begin
    if (cyc_o) cyc_n++;
    if (cyc_o && stb_o && ack_i) adr_q.push_back(adr_o);
    if (wr_rdy_o) wr_n++;
    if (rd_vld_o) rd_q.push_back(rd_dat_o);
    if (done_o) done_n++;
    if (err_o) err_n++;
  end

  int n_vec = 0, n_err = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic start(input logic we, input logic [11:0] adr, input logic [3:0] len);
    @(posedge clk_i); #1;
    cyc_n = 0; wr_n = 0; done_n = 0; err_n = 0;
    adr_q.delete(); rd_q.delete(); wbase = widx;
    req_i = 1; req_we_i = we; req_adr_i = adr; req_len_i = len;
    @(posedge clk_i); #1;
    req_i = 0;
  endtask

  task automatic finish_blk(input string tag);
    int n = 0;
    while (done_n + err_n == 0 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, "_end"}, 64'(n < 200), 64'd1);
    @(negedge clk_i);
  endtask

  initial begin
    wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33; wdata[3] = 8'h44;
    #12;
    check("rst_ctl", {busy_o, cyc_o, stb_o, done_o, err_o, rd_vld_o, wr_rdy_o, we_o}, 0);
    check("rst_adr", adr_o, 0);
    check("rst_dat", {rd_dat_o, dat_o}, 0);
    @(negedge clk_i); rst_i = 1;

    start(0, 12'h010, 4'd0);
    finish_blk("rd1");
    check("rd1_cyc", cyc_n, 1);
    check("rd1_adr", {adr_q.size(), adr_q[0]}, {32'd1, 12'h010});
    check("rd1_dat", {rd_q.size(), rd_q[0]}, {32'd1, 8'h5A});
    check("rd1_end", {done_n, err_n}, {32'd1, 32'd0});

    start(1, 12'h100, 4'd3);
    finish_blk("wr4");
    check("wr4_cyc", cyc_n, 4);
    check("wr4_nadr", adr_q.size(), 4);
    check("wr4_adr", {adr_q[0], adr_q[1], adr_q[2], adr_q[3]}, {12'h100, 12'h101, 12'h102, 12'h103});
    check("wr4_rdy", wr_n, 4);
    check("wr4_mem", {wmem[12'h100], wmem[12'h101], wmem[12'h102], wmem[12'h103]}, 32'h11223344);
    check("wr4_end", {done_n, err_n}, {32'd1, 32'd0});
    check("idle_dat", {dat_o, busy_o}, 0);

    start(0, 12'hFFE, 4'd3);
    finish_blk("wrap");
    check("wrap_nadr", adr_q.size(), 4);
    check("wrap_adr", {adr_q[0], adr_q[1], adr_q[2], adr_q[3]}, {12'hFFE, 12'hFFF, 12'h000, 12'h001});
    check("wrap_rd", {rd_q[0], rd_q[1], rd_q[2], rd_q[3]}, 32'h48494A4B);

    noack = 1;
    start(0, 12'h020, 4'd0);
    finish_blk("tmo");
    check("tmo_cyc", cyc_n, 16);
    check("tmo_end", {done_n, err_n}, {32'd0, 32'd1});
    check("tmo_idle", {busy_o, cyc_o, stb_o, rd_vld_o}, 0);
    noack = 0;

    waits = 3;
    start(0, 12'h030, 4'd1);
    finish_blk("wait");
    check("wait_cyc", cyc_n, 8);
    check("wait_adr", {adr_q.size(), adr_q[0], adr_q[1]}, {32'd2, 12'h030, 12'h031});
    check("wait_end", {done_n, err_n}, {32'd1, 32'd0});
    waits = 0;

    start(0, 12'h200, 4'd7);
    @(posedge clk_i); #1;
    rst_i = 0; #1;
    check("rst_mid", {cyc_o, stb_o, busy_o}, 0);
    @(negedge clk_i); rst_i = 1;
    start(0, 12'h040, 4'd1);
    finish_blk("post");
    check("post_adr", {adr_q.size(), adr_q[0], adr_q[1]}, {32'd2, 12'h040, 12'h041});
    check("post_end", {done_n, err_n}, {32'd1, 32'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
